// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute-stage control path and the
// multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider that owns HI/LO.
// Signed ops run on magnitudes; the sign is restored in a single FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div_q;
    logic               neg_q;
    logic               neg_r_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // acc_q holds {partial product, remaining multiplier} for MUL and
    // {partial remainder, dividend/quotient bits} for DIV.
    always_comb begin
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                acc_q    <= {{WIDTH{1'b0}}, b_mag};
                                opnd_q   <= a_mag;
                                neg_q    <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_r_q  <= 1'b0;
                                is_div_q <= 1'b0;
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (bus.b == '0) begin
                                    done_q  <= 1'b1;
                                    dbz_q   <= 1'b1;
                                    state_q <= DONE;
                                end else begin
                                    acc_q    <= {{WIDTH{1'b0}}, a_mag};
                                    opnd_q   <= b_mag;
                                    neg_q    <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                    neg_r_q  <= is_signed && bus.a[WIDTH-1];
                                    is_div_q <= 1'b1;
                                    cnt_q    <= '0;
                                    busy_q   <= 1'b1;
                                    state_q  <= DIV;
                                end
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                DIV: begin
                    // A negative trial difference means the divisor did not fit: keep the shifted remainder.
                    if (div_diff[WIDTH])
                        acc_q <= {acc_q[2*WIDTH-2:0], 1'b0};
                    else
                        acc_q <= {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
